// File: rtl/stopwatch_disp_pkg.sv
// Shared types and constants for the stopwatch display back-end.
// Optional leading-zero blanking is enabled by STOPWATCH_DISP_LZB_EN.
package stopwatch_disp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [1:0] DIG_SEC_ONES = 2'd0;
    localparam logic [1:0] DIG_SEC_TENS = 2'd1;
    localparam logic [1:0] DIG_MIN_ONES = 2'd2;
    localparam logic [1:0] DIG_MIN_TENS = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam int SHIFT_STEPS = 6;

    // Active-low {g,f,e,d,c,b,a}, entry 0 in the low slot
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        s = SEG_BLANK;
        if (d <= 4'd9) s = SEG_TABLE[d];
        return s;
    endfunction

endpackage

// File: rtl/stopwatch_display_bin2bcd6_seq.sv
// Sequential shift-add-3 converter: 6-bit binary to two BCD digits.
// Sequenced externally via load/step.
module bin2bcd6_seq
    import stopwatch_disp_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [5:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [5:0]  shreg;
    logic [7:0]  bcd;
    logic [3:0]  adj_t;
    logic [3:0]  adj_o;
    logic [13:0] nxt;

    always_comb begin
        adj_o = (bcd[3:0] >= 4'd5) ? bcd[3:0] + 4'd3 : bcd[3:0];
        adj_t = (bcd[7:4] >= 4'd5) ? bcd[7:4] + 4'd3 : bcd[7:4];
        nxt   = {adj_t, adj_o, shreg} << 1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            shreg <= '0;
            bcd   <= '0;
        end else if (load) begin
            shreg <= bin;
            bcd   <= '0;
        end else if (step) begin
            bcd   <= nxt[13:6];
            shreg <= nxt[5:0];
        end
    end

    assign tens = bcd[7:4];
    assign ones = bcd[3:0];

endmodule

// File: rtl/stopwatch_display.sv
// MM.SS display back-end: snapshot, BCD conversion, 4-digit scan.
// Define STOPWATCH_DISP_LZB_EN to blank a zero minutes-tens digit.
module stopwatch_display
    import stopwatch_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       busy
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(SCAN_DIV - 1);

    state_t state;
    state_t state_nx;

    logic [5:0]      snap_min;
    logic [5:0]      snap_sec;
    logic [2:0]      cnt;
    logic            load;
    logic            step;
    logic            commit;
    logic [3:0]      min_t;
    logic [3:0]      min_o;
    logic [3:0]      sec_t;
    logic [3:0]      sec_o;
    logic [3:0][3:0] dig;
    logic [PW-1:0]   pre;
    logic [1:0]      idx;
    logic [6:0]      cur_seg;

    bin2bcd6_seq u_min (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .bin   (min),
        .tens  (min_t),
        .ones  (min_o)
    );

    bin2bcd6_seq u_sec (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .bin   (sec),
        .tens  (sec_t),
        .ones  (sec_o)
    );

    always_comb begin
        state_nx = state;
        load     = 1'b0;
        step     = 1'b0;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if ({min, sec} != {snap_min, snap_sec}) begin
                    load     = 1'b1;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                step = 1'b1;
                if (cnt == 3'(SHIFT_STEPS - 1)) state_nx = COMMIT;
            end
            COMMIT: begin
                commit   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // busy also covers the cycle after COMMIT so the full pass reads as 8
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            busy     <= 1'b0;
            snap_min <= '0;
            snap_sec <= '0;
            cnt      <= '0;
            dig      <= '0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != IDLE) || (state != IDLE);
            if (load) begin
                snap_min <= min;
                snap_sec <= sec;
                cnt      <= '0;
            end
            if (step) cnt <= cnt + 3'd1;
            if (commit) begin
                dig[DIG_SEC_ONES] <= sec_o;
                dig[DIG_SEC_TENS] <= sec_t;
                dig[DIG_MIN_ONES] <= min_o;
                dig[DIG_MIN_TENS] <= min_t;
            end
        end
    end

    always_comb begin
        cur_seg = seg_decode(dig[idx]);
`ifdef STOPWATCH_DISP_LZB_EN
        if (idx == DIG_MIN_TENS && dig[DIG_MIN_TENS] == 4'd0)
            cur_seg = SEG_BLANK;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pre <= '0;
            idx <= '0;
            seg <= SEG_BLANK;
            an  <= 4'hF;
            dp  <= 1'b1;
        end else begin
            if (pre == PRE_LAST) begin
                pre <= '0;
                idx <= idx + 2'd1;
            end else begin
                pre <= pre + PW'(1);
            end
            an  <= ~(4'b0001 << idx);
            seg <= cur_seg;
            dp  <= (idx != DIG_MIN_ONES);
        end
    end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Display back-end for the stopwatch. It consumes the binary `min`/`sec` counts (0–59 each) from the stopwatch counter stage and converts each to two BCD digits with a sequential shift-add-3 converter. It then time-multiplexes the four digits onto a common-anode 4-digit 7-segment display as MM.SS. It is the stage directly downstream of the stopwatch counter and directly drives board pins.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clk cycles each digit stays lit. Legal range ≥1.

Ports:
- `clk`  in  1  system clock; one clock domain, all logic on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `sec`  in  6  binary seconds from the counter stage.
- `min`  in  6  binary minutes from the counter stage.
- `seg`  out  7  segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1  decimal point, active-low.
- `an`  out  4  digit enables, one-hot active-low. an[0] is the rightmost digit.
- `busy`  out  1  high while a conversion is in progress.

## Operation
- **Snapshot registers** `snap_min` and `snap_sec`, each 6 bits.
- **Converter FSM** states IDLE, SHIFT, COMMIT.
  - IDLE: if {min,sec} ≠ {snap_min,snap_sec}:
    - capture the inputs into the snapshots;
    - clear both BCD scratch registers;
    - set shift count to 0;
    - go to SHIFT.
  - SHIFT: for each value, every BCD nibble ≥5 gets +3, then the register shifts left 1 with the next binary MSB. After 6 SHIFT cycles, go to COMMIT.
  - COMMIT: load the digit registers d0=sec ones, d1=sec tens, d2=min ones, d3=min tens, then go to IDLE.
- Min and sec convert in parallel in the same FSM pass.
- Inputs 60–63 are not clamped; they convert normally (tens digit 6). Tens is always ≤6.
- **Scanner:**
  - A prescaler counts 0..SCAN_DIV-1.
  - At terminal count, the prescaler wraps and the 2-bit scan index increments 0→1→2→3→0.
  - The index selects a digit and asserts the matching `an` bit low.
- **Decode:**
  - Digit codes 0–9 map to standard patterns.
  - Codes 10–15 map to all segments off.
  - `dp` is low only while index=2 (separator after the minutes).

## Timing
- **Reset values:**
  - `seg`=7'h7F, `an`=4'hF, `dp`=1, `busy`=0;
  - digit registers, snapshots, prescaler and scan index = 0;
  - FSM in IDLE.
- **First cycle after reset release:** the scanner drives index 0. Because the snapshot equals 00:00, no conversion starts if the inputs are 0.
- **Conversion latency:**
  - The mismatch is sampled in IDLE at edge E0.
  - SHIFT runs on edges E1–E6; COMMIT is E7.
  - The new digit registers are valid after E7.
  - `busy` is high from after E0 through E7.
- **Output registering:** `seg`, `an` and `dp` are registered. They reflect the scan index and digit registers one cycle after either changes.
- **Input change during SHIFT/COMMIT:** ignored by the running conversion. The first IDLE cycle afterwards detects the mismatch and starts a new conversion. The display never shows a partially converted value.
- **Reset low mid-conversion:** aborts immediately on that edge; all state returns to the reset values.
- **SCAN_DIV=1:** the index advances every cycle.
- **Prescaler width:** max(1, $clog2(SCAN_DIV)).

## Configuration
- Macro: `STOPWATCH_DISP_LZB_EN`.
- **Defined:** leading-zero blanking. When d3==0, digit 3 shows all segments off while its `an` bit is still scanned. d2 is never blanked, so 00:05 shows " 0.05".
- **Undefined:** d3 always displays its value ("00.05").

## Structure
- **Package `stopwatch_disp_pkg`:**
  - FSM state encoding (IDLE, SHIFT, COMMIT);
  - digit index constants (DIG_SEC_ONES=0 … DIG_MIN_TENS=3);
  - SEG_BLANK=7'h7F;
  - the 7-segment code table for 0–9;
  - SHIFT_STEPS=6.
- **Sub-module `bin2bcd6_seq`:** one 6-bit shift-add-3 datapath (6-bit binary in, 2×4-bit BCD out, step/load controls). It is instantiated twice, for min and sec, and sequenced by the top-level FSM.

## Test plan
- **Reset:** hold `reset`=0 for 3 cycles with inputs 00:00 -> `seg`=7F, `an`=F, `dp`=1, `busy`=0. After release, with SCAN_DIV=4, `an` cycles E,D,B,7 every 4 cycles; `seg` shows 0 on every digit; `dp`=0 only when `an`=B.
- **Conversion:** apply min=12, sec=59 -> `busy` high for exactly 8 cycles, then digits d0..d3 = 9,5,2,1. Check `seg` against the package table at each `an` position.
- **Change mid-conversion:** apply sec=59, then sec=7 three cycles later -> the first conversion commits 59. A second conversion then starts and commits 07; no other value ever appears.
- **Boundary:** min=59, sec=59, then min=0, sec=0 -> digits 9,5,9,5, then 0,0,0,0. Input 63 on sec -> digits 3,6.
- **Leading-zero blanking:** with `STOPWATCH_DISP_LZB_EN`, min=5, sec=0 -> digit 3 `seg`=7F and digit 2 shows 5. With min=10, digit 3 shows 1. Without the macro, digit 3 shows 0.
- **Reset mid-conversion:** drive `reset`=0 at the 3rd SHIFT cycle -> next edge: `busy`=0, digits=0, snapshots=0. After release, the unchanged nonzero inputs trigger a fresh full 8-cycle conversion.
